// File: rtl/wb_regfile.sv
// wb_regfile: architectural register file fed by the write-back stage.
// A write-back slot is staged for one cycle and then committed to a
// 2^ADDR_W-entry array. Two combinational read ports resolve, in order:
// index 0, live write-back input (optional), staging register, array.
// Optional feature macro: WB_REGFILE_INPUT_BYPASS_EN forwards the live
// write-back input to the read ports in the same cycle.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              stg_busy,
    output logic [31:0]       retired_count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic              r_stg_valid;
    logic [ADDR_W-1:0] r_stg_rd;
    logic [DATA_W-1:0] r_stg_data;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [31:0]       r_retired_count;

    logic              w_wb_take;
    logic              w_rs1_zero;
    logic              w_rs2_zero;
    logic              w_rs1_stg_hit;
    logic              w_rs2_stg_hit;
    logic              w_rs1_wb_hit;
    logic              w_rs2_wb_hit;

    // Writes to register 0 are architecturally discarded and never stage.
    assign w_wb_take = wb_valid && (wb_rd != '0);

    assign w_rs1_zero    = (rs1_addr == '0);
    assign w_rs2_zero    = (rs2_addr == '0);
    assign w_rs1_stg_hit = r_stg_valid && (r_stg_rd == rs1_addr);
    assign w_rs2_stg_hit = r_stg_valid && (r_stg_rd == rs2_addr);

`ifdef WB_REGFILE_INPUT_BYPASS_EN
    assign w_rs1_wb_hit = w_wb_take && (wb_rd == rs1_addr);
    assign w_rs2_wb_hit = w_wb_take && (wb_rd == rs2_addr);
`else
    assign w_rs1_wb_hit = 1'b0;
    assign w_rs2_wb_hit = 1'b0;
`endif

    // Stage the incoming write-back slot for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_valid <= 1'b0;
            r_stg_rd    <= '0;
            r_stg_data  <= '0;
        end else begin
            r_stg_valid <= w_wb_take;
            r_stg_rd    <= wb_rd;
            r_stg_data  <= wb_data;
        end
    end

    // Commit the staged write; a write staged when reset hits is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_stg_valid) begin
            r_mem[r_stg_rd] <= r_stg_data;
        end
    end

    // Count every accepted write-back slot, including those to register 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired_count <= '0;
        end else if (wb_valid) begin
            r_retired_count <= r_retired_count + 32'd1;
        end
    end

    // Read port 1: zero register, live input, staging, then array.
    always_comb begin
        rs1_data = r_mem[rs1_addr];
        if (w_rs1_zero) begin
            rs1_data = '0;
        end else if (w_rs1_wb_hit) begin
            rs1_data = wb_data;
        end else if (w_rs1_stg_hit) begin
            rs1_data = r_stg_data;
        end
    end

    // Read port 2: same resolution order as port 1, independently.
    always_comb begin
        rs2_data = r_mem[rs2_addr];
        if (w_rs2_zero) begin
            rs2_data = '0;
        end else if (w_rs2_wb_hit) begin
            rs2_data = wb_data;
        end else if (w_rs2_stg_hit) begin
            rs2_data = r_stg_data;
        end
    end

    assign stg_busy      = r_stg_valid;
    assign retired_count = r_retired_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: the driver pushes expected read/status
// values tagged with the cycle they apply to; a negedge monitor pops them.
module tb_wb_regfile;

`ifdef WB_REGFILE_INPUT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int SEL_RS1  = 0;
    localparam int SEL_RS2  = 1;
    localparam int SEL_BUSY = 2;
    localparam int SEL_CNT  = 3;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        stg_busy;
    logic [31:0] retired_count;

    typedef struct {
        int          cyc;
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t        q[$];
    chk_t        e;
    logic [31:0] act;
    int          cyc;
    int          checks;
    int          errors;

    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .stg_busy      (stg_busy),
        .retired_count (retired_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            case (e.sel)
                SEL_RS1:  act = rs1_data;
                SEL_RS2:  act = rs2_data;
                SEL_BUSY: act = {31'd0, stg_busy};
                default:  act = retired_count;
            endcase
            checks++;
            if (e.cyc != cyc || act !== e.exp) begin
                errors++;
                $display("FAIL %s (cycle %0d/%0d): got 0x%08h expected 0x%08h",
                         e.name, cyc, e.cyc, act, e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic step(input logic v, input logic [4:0] rd, input logic [31:0] d,
                        input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk);
        #1;
        wb_valid = v;
        wb_rd    = rd;
        wb_data  = d;
        rs1_addr = a1;
        rs2_addr = a2;
    endtask

    task automatic expect_val(input string n, input int sel, input logic [31:0] v);
        chk_t c;
        c.cyc  = cyc;
        c.name = n;
        c.sel  = sel;
        c.exp  = v;
        q.push_back(c);
    endtask

    task automatic expect_status(input logic busy, input logic [31:0] cnt);
        expect_val("stg_busy", SEL_BUSY, {31'd0, busy});
        expect_val("retired_count", SEL_CNT, cnt);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        wb_valid = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        rs1_addr = '0;
        rs2_addr = '0;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;

        // Reset state
        step(1'b0, 5'd0, 32'h0, 5'd3, 5'd17);
        expect_val("reset_rs1", SEL_RS1, 32'h0);
        expect_val("reset_rs2", SEL_RS2, 32'h0);
        expect_status(1'b0, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Write 5 <- DEADBEEF: same-cycle visibility depends on bypass
        step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        expect_val("wr5_cycN_rs1", SEL_RS1, BYP ? 32'hDEADBEEF : 32'h0);
        expect_val("wr5_cycN_rs2_idx0", SEL_RS2, 32'h0);
        expect_status(1'b0, 32'd0);
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        expect_val("wr5_staged_rs1", SEL_RS1, 32'hDEADBEEF);
        expect_val("wr5_staged_rs2", SEL_RS2, 32'hDEADBEEF);
        expect_status(1'b1, 32'd1);
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
        expect_val("wr5_committed", SEL_RS1, 32'hDEADBEEF);
        expect_val("idx6_untouched", SEL_RS2, 32'h0);
        expect_status(1'b0, 32'd1);

        // Write to register 0: counted but never staged or readable
        step(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
        expect_val("r0_cycN_rs1", SEL_RS1, 32'h0);
        expect_val("r0_cycN_rs2", SEL_RS2, 32'h0);
        expect_status(1'b0, 32'd1);
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        expect_val("r0_after_rs1", SEL_RS1, 32'h0);
        expect_val("r0_after_rs2", SEL_RS2, 32'h0);
        expect_status(1'b0, 32'd2);

        // Back-to-back writes to 7
        step(1'b1, 5'd7, 32'h1, 5'd7, 5'd5);
        expect_val("b2b_n_rs1", SEL_RS1, BYP ? 32'h1 : 32'h0);
        expect_val("b2b_n_rs2", SEL_RS2, 32'hDEADBEEF);
        step(1'b1, 5'd7, 32'h2, 5'd7, 5'd7);
        expect_val("b2b_n1_rs1", SEL_RS1, BYP ? 32'h2 : 32'h1);
        expect_status(1'b1, 32'd3);
        step(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        expect_val("b2b_n2_rs1", SEL_RS1, 32'h2);
        expect_val("b2b_n2_rs2", SEL_RS2, 32'h2);
        expect_status(1'b1, 32'd4);
        step(1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
        expect_val("b2b_n3_rs1", SEL_RS1, 32'h2);
        expect_status(1'b0, 32'd4);

        // Same index on both ports with a staged write
        step(1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9);
        expect_val("dual9_n_rs1", SEL_RS1, BYP ? 32'hA5A5A5A5 : 32'h0);
        expect_val("dual9_n_rs2", SEL_RS2, BYP ? 32'hA5A5A5A5 : 32'h0);
        step(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        expect_val("dual9_stg_rs1", SEL_RS1, 32'hA5A5A5A5);
        expect_val("dual9_stg_rs2", SEL_RS2, 32'hA5A5A5A5);
        expect_status(1'b1, 32'd5);

        // Stage a write to 12, then reset while it is still staged
        step(1'b1, 5'd12, 32'hCAFE0012, 5'd12, 5'd9);
        expect_val("w12_n_rs1", SEL_RS1, BYP ? 32'hCAFE0012 : 32'h0);
        expect_val("w12_n_rs2", SEL_RS2, 32'hA5A5A5A5);
        expect_status(1'b0, 32'd5);
        step(1'b0, 5'd0, 32'h0, 5'd12, 5'd9);
        expect_val("w12_stg_rs1", SEL_RS1, 32'hCAFE0012);
        expect_status(1'b1, 32'd6);
        @(negedge clk);
        #1 rst_n = 1'b0;
        step(1'b0, 5'd0, 32'h0, 5'd12, 5'd9);
        expect_val("rst_mid_rs1", SEL_RS1, 32'h0);
        expect_val("rst_mid_rs2", SEL_RS2, 32'h0);
        expect_status(1'b0, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // After release every index reads 0; staged write was discarded
        for (int i = 1; i < 32; i += 2) begin
            logic [4:0] a1;
            logic [4:0] a2;
            a1 = 5'(i);
            a2 = 5'(i + 1);
            step(1'b0, 5'd0, 32'h0, a1, a2);
            expect_val($sformatf("post_rst_rs1_%0d", i), SEL_RS1, 32'h0);
            expect_val($sformatf("post_rst_rs2_%0d", i + 1), SEL_RS2, 32'h0);
        end
        expect_status(1'b0, 32'd0);

        // Counter wrap from 0xFFFFFFFF
        step(1'b1, 5'd3, 32'h00000033, 5'd3, 5'd0);
        force dut.r_retired_count = 32'hFFFFFFFF;
        expect_val("wrap_pre_cnt", SEL_CNT, 32'hFFFFFFFF);
        expect_val("wrap_pre_rs1", SEL_RS1, BYP ? 32'h00000033 : 32'h0);
        @(negedge clk);
        #1 release dut.r_retired_count;
        step(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        expect_val("wrap_cnt", SEL_CNT, 32'h0);
        expect_val("wrap_rs1", SEL_RS1, 32'h00000033);
        expect_val("wrap_rs2", SEL_RS2, 32'h00000033);
        expect_val("wrap_busy", SEL_BUSY, 32'h1);

        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
